sdram_req_master: RTL

//  Request initiator for the SDRAM controller's write/read port pair. It watches the levels of
//  an external write FIFO (camera side) and read FIFO (LCD side). It issues sdram_wr_req /

---
 rtl/sdram_req_master_if.sv | 28 ++
 rtl/sdram_req_master.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_req_master_if.sv
// Request/acknowledge bundle between the request master and the SDRAM controller.
// The master drives the write/read requests with their burst address and length.
// The controller answers each accepted write beat or valid read beat with an ack.
interface sdram_req_master_if #(
  parameter int AW = 24,
  parameter int BW = 10
);
  logic          sdram_wr_req;
  logic          sdram_wr_ack;
  logic [AW-1:0] sdram_wr_addr;
  logic [BW-1:0] sdram_wr_burst;
  logic          sdram_rd_req;
  logic          sdram_rd_ack;
  logic [AW-1:0] sdram_rd_addr;
  logic [BW-1:0] sdram_rd_burst;

  modport master (
    output sdram_wr_req, sdram_wr_addr, sdram_wr_burst,
    output sdram_rd_req, sdram_rd_addr, sdram_rd_burst,
    input  sdram_wr_ack, sdram_rd_ack
  );

  modport slave (
    input  sdram_wr_req, sdram_wr_addr, sdram_wr_burst,
    input  sdram_rd_req, sdram_rd_addr, sdram_rd_burst,
    output sdram_wr_ack, sdram_rd_ack
  );
endinterface

// File: rtl/sdram_req_master.sv
// SDRAM request initiator for the camera write FIFO and the LCD read FIFO.
// It watches both FIFO levels and issues write/read burst requests. Each side
// walks its own frame address window and wraps to the window start whenever
// the next burst would not fit.
// Optional build macro SDRAM_PINGPONG_EN: the address MSB selects one of two
// frame buffers. The write buffer toggles on each write wrap. The read buffer
// takes the opposite of the write buffer on each read wrap or read reload.
//
// state    | meaning
// IDLE     | arbitrate between pending write and read bursts
// WR_REQ   | write request raised, waiting for first ack
// WR_BURST | write beats in flight, ends when ack falls
// RD_REQ   | read request raised, waiting for first ack
// RD_BURST | read beats in flight, ends when ack falls
module sdram_req_master #(
  parameter int RD_FIFO_DEPTH = 1024,
  parameter int AW            = 24,
  parameter int BW            = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sdram_init_done,
  input  logic [AW-1:0] wr_min_addr,
  input  logic [AW-1:0] wr_max_addr,
  input  logic [BW-1:0] wr_len,
  input  logic          wr_load,
  input  logic [BW-1:0] wr_fifo_used,
  output logic          wr_fifo_rdreq,
  input  logic [AW-1:0] rd_min_addr,
  input  logic [AW-1:0] rd_max_addr,
  input  logic [BW-1:0] rd_len,
  input  logic          rd_load,
  input  logic          rd_en,
  input  logic [BW-1:0] rd_fifo_used,
  output logic          rd_fifo_wrreq,
  sdram_req_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_BURST,
    RD_REQ,
    RD_BURST
  } state_t;

  localparam logic [BW:0] RD_DEPTH_W = (BW+1)'(RD_FIFO_DEPTH);

  state_t        state;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_load_flag, rd_load_flag;
  logic          last_wr;

  logic [AW-1:0] wr_min_m, wr_max_m, rd_min_m, rd_max_m;
  logic [AW-1:0] wr_ptr_cur, rd_ptr_cur;
  logic [AW-1:0] wr_addr_cur, rd_addr_cur;
  logic [AW:0]   wr_step, rd_step;
  logic          wr_wrap, rd_wrap;
  logic [AW-1:0] wr_next, rd_next;
  logic [BW:0]   rd_sum;
  logic          wr_pend, rd_pend, grant_wr, grant_rd;
`ifdef SDRAM_PINGPONG_EN
  logic          wr_buf, rd_buf, rd_buf_cur;
`endif

  // The FIFO strobes are the acks themselves: one pop/push per accepted beat.
  assign wr_fifo_rdreq = bus.sdram_wr_ack;
  assign rd_fifo_wrreq = bus.sdram_rd_ack;

  // Pending/grant decision and next-pointer arithmetic.
  always_comb begin
    wr_min_m = wr_min_addr;
    wr_max_m = wr_max_addr;
    rd_min_m = rd_min_addr;
    rd_max_m = rd_max_addr;
`ifdef SDRAM_PINGPONG_EN
    // The buffer bit is owned by this block; window MSBs from outside are ignored.
    wr_min_m[AW-1] = 1'b0;
    wr_max_m[AW-1] = 1'b0;
    rd_min_m[AW-1] = 1'b0;
    rd_max_m[AW-1] = 1'b0;
`endif
    // A pending reload takes effect in the same IDLE cycle that may also grant.
    wr_ptr_cur = wr_load_flag ? wr_min_m : wr_ptr;
    rd_ptr_cur = rd_load_flag ? rd_min_m : rd_ptr;
`ifdef SDRAM_PINGPONG_EN
    rd_buf_cur  = rd_load_flag ? ~wr_buf : rd_buf;
    wr_addr_cur = {wr_buf, wr_ptr_cur[AW-2:0]};
    rd_addr_cur = {rd_buf_cur, rd_ptr_cur[AW-2:0]};
`else
    wr_addr_cur = wr_ptr_cur;
    rd_addr_cur = rd_ptr_cur;
`endif

    wr_pend = (wr_len != '0) && (wr_fifo_used >= wr_len);
    rd_sum  = {1'b0, rd_fifo_used} + {1'b0, rd_len};
    rd_pend = rd_en && (rd_len != '0) && (rd_sum <= RD_DEPTH_W);
    // With both sides pending, the side not served last wins.
    grant_wr = wr_pend && (!rd_pend || !last_wr);
    grant_rd = rd_pend && !grant_wr;

    // Wrap rather than split a burst at the window end.
    wr_step = {1'b0, wr_ptr} + (AW+1)'(bus.sdram_wr_burst);
    wr_wrap = ({1'b0, wr_step} + (AW+2)'(bus.sdram_wr_burst)) > {2'b00, wr_max_m};
    wr_next = wr_wrap ? wr_min_m : wr_step[AW-1:0];
    rd_step = {1'b0, rd_ptr} + (AW+1)'(bus.sdram_rd_burst);
    rd_wrap = ({1'b0, rd_step} + (AW+2)'(bus.sdram_rd_burst)) > {2'b00, rd_max_m};
    rd_next = rd_wrap ? rd_min_m : rd_step[AW-1:0];
  end

  // Request FSM, window pointers, reload flags and registered request outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      wr_load_flag       <= 1'b0;
      rd_load_flag       <= 1'b0;
      last_wr            <= 1'b0;
      bus.sdram_wr_req   <= 1'b0;
      bus.sdram_wr_addr  <= '0;
      bus.sdram_wr_burst <= '0;
      bus.sdram_rd_req   <= 1'b0;
      bus.sdram_rd_addr  <= '0;
      bus.sdram_rd_burst <= '0;
`ifdef SDRAM_PINGPONG_EN
      wr_buf             <= 1'b0;
      rd_buf             <= 1'b0;
`endif
    end else begin
      // Loads seen outside IDLE are held; the running burst is never disturbed.
      wr_load_flag <= (state == IDLE) ? wr_load : (wr_load_flag | wr_load);
      rd_load_flag <= (state == IDLE) ? rd_load : (rd_load_flag | rd_load);
      case (state)
        IDLE: begin
          wr_ptr <= wr_ptr_cur;
          rd_ptr <= rd_ptr_cur;
`ifdef SDRAM_PINGPONG_EN
          rd_buf <= rd_buf_cur;
`endif
          if (sdram_init_done && grant_wr) begin
            state              <= WR_REQ;
            bus.sdram_wr_req   <= 1'b1;
            bus.sdram_wr_addr  <= wr_addr_cur;
            bus.sdram_wr_burst <= wr_len;
            last_wr            <= 1'b1;
          end else if (sdram_init_done && grant_rd) begin
            state              <= RD_REQ;
            bus.sdram_rd_req   <= 1'b1;
            bus.sdram_rd_addr  <= rd_addr_cur;
            bus.sdram_rd_burst <= rd_len;
            last_wr            <= 1'b0;
          end
        end
        WR_REQ: begin
          if (bus.sdram_wr_ack) begin
            bus.sdram_wr_req <= 1'b0;
            state            <= WR_BURST;
          end
        end
        WR_BURST: begin
          if (!bus.sdram_wr_ack) begin
            state  <= IDLE;
            wr_ptr <= wr_next;
`ifdef SDRAM_PINGPONG_EN
            if (wr_wrap) wr_buf <= ~wr_buf;
`endif
          end
        end
        RD_REQ: begin
          if (bus.sdram_rd_ack) begin
            bus.sdram_rd_req <= 1'b0;
            state            <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (!bus.sdram_rd_ack) begin
            state  <= IDLE;
            rd_ptr <= rd_next;
`ifdef SDRAM_PINGPONG_EN
            if (rd_wrap) rd_buf <= ~wr_buf;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
